ecc_decode_ctrl: RTL



---
 rtl/ecc_decode_ctrl_pkg.sv | 63 ++++++
 rtl/ecc_decode_ctrl_syndrome.sv | 40 ++++
 rtl/ecc_decode_ctrl.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/ecc_decode_ctrl_pkg.sv
// ecc_pkg: shared types and constants for the SECDED (16,11) decode slice.
//   ecc_state_t    - sequencer states of ecc_decode_ctrl
//   ECC_*          - 2-bit error flag written in the decoded MSW
//   *_POS_*        - Hamming position layout of the encoded {MSW,LSW} word
//   ecc_data_bits  - gathers b11..b1 out of a 16-bit codeword
package ecc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_LO,
    ST_RD_HI,
    ST_CHECK,
    ST_WR_LO,
    ST_WR_HI,
    ST_DONE
  } ecc_state_t;

  localparam logic [1:0] ECC_OK  = 2'b00;
  localparam logic [1:0] ECC_SEC = 2'b01;
  localparam logic [1:0] ECC_DED = 2'b10;

  // In {MSW,LSW} the bit index equals the Hamming position: LSW bit i is
  // position i (bit 0 = p0, the overall parity), MSW bit i is position i+8.
  localparam int unsigned LSW_POS_BASE = 0;
  localparam int unsigned MSW_POS_BASE = 8;

  // Positions of the parity bits.
  localparam int unsigned POS_P1 = 1;
  localparam int unsigned POS_P2 = 2;
  localparam int unsigned POS_P4 = 4;
  localparam int unsigned POS_P8 = 8;

  // Positions of the data bits.
  localparam int unsigned POS_B1  = 3;
  localparam int unsigned POS_B2  = 5;
  localparam int unsigned POS_B3  = 6;
  localparam int unsigned POS_B4  = 7;
  localparam int unsigned POS_B5  = 9;
  localparam int unsigned POS_B6  = 10;
  localparam int unsigned POS_B7  = 11;
  localparam int unsigned POS_B8  = 12;
  localparam int unsigned POS_B9  = 13;
  localparam int unsigned POS_B10 = 14;
  localparam int unsigned POS_B11 = 15;

  // Returns {b11,...,b1}; bit 0 of the result is b1.
  function automatic logic [10:0] ecc_data_bits(input logic [15:0] cw);
    logic [10:0] d;
    d[0]  = cw[POS_B1];
    d[1]  = cw[POS_B2];
    d[2]  = cw[POS_B3];
    d[3]  = cw[POS_B4];
    d[4]  = cw[POS_B5];
    d[5]  = cw[POS_B6];
    d[6]  = cw[POS_B7];
    d[7]  = cw[POS_B8];
    d[8]  = cw[POS_B9];
    d[9]  = cw[POS_B10];
    d[10] = cw[POS_B11];
    return d;
  endfunction

endpackage

// File: rtl/ecc_decode_ctrl_syndrome.sv
// ecc_syndrome: combinational SECDED (16,11) check and single-bit correction.
//   code_i [15:0] - encoded word {MSW,LSW}; bit index == Hamming position
//   data_o [10:0] - decoded data {b11..b1}, corrected when flag_o is SEC
//   flag_o [1:0]  - ECC_OK / ECC_SEC / ECC_DED
module ecc_syndrome
  import ecc_pkg::*;
(
  input  logic [15:0] code_i,
  output logic [10:0] data_o,
  output logic [1:0]  flag_o
);

  logic [3:0]  syn;
  logic        par;
  logic [15:0] fixed;

  always_comb begin
    syn = '0;
    for (int unsigned i = 1; i < 16; i++) begin
      if (code_i[i]) begin
        syn = syn ^ 4'(i);
      end
    end
    par   = ^code_i;
    fixed = code_i;
    flag_o = ECC_OK;
    if (par) begin
      // Odd overall parity: single error. s==0 means only p0 flipped,
      // which carries no data, so nothing needs inverting.
      flag_o = ECC_SEC;
      if (syn != '0) begin
        fixed[syn] = ~fixed[syn];
      end
    end else if (syn != '0) begin
      flag_o = ECC_DED;
    end
    data_o = ecc_data_bits(fixed);
  end

endmodule

// File: rtl/ecc_decode_ctrl.sv
// ecc_decode_ctrl: sequencer for the SECDED (16,11) decode job.
// On an accepted start it decodes `count` encoded 16-bit words starting at
// src_base (LSW, MSW byte pairs) and writes decoded pairs starting at
// dst_base, counting corrected and uncorrectable words.
//   clk, rst_n          - clock, synchronous active-low reset
//   start               - job request, honoured only in IDLE
//   src_base, dst_base  - byte addresses of the first source / result LSW
//   count               - number of words in the job
//   mem_addr/we/wdata   - data-memory request port (owned during a job)
//   mem_rdata           - read data, one cycle after the address
//   busy, done          - job active / one-cycle completion pulse
//   n_single, n_double  - corrected / uncorrectable word counts (saturating)
module ecc_decode_ctrl
  import ecc_pkg::*;
#(
  parameter int unsigned CNT_W  = 8,
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] src_base,
  input  logic [ADDR_W-1:0] dst_base,
  input  logic [CNT_W-1:0]  count,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  n_single,
  output logic [CNT_W-1:0]  n_double
);

  ecc_state_t        state_q, state_d;
  logic [ADDR_W-1:0] src_q, src_d;
  logic [ADDR_W-1:0] dst_q, dst_d;
  logic [CNT_W-1:0]  rem_q, rem_d;
  logic [7:0]        lsw_q, lsw_d;
  logic [10:0]       dec_data_q, dec_data_d;
  logic [1:0]        dec_flag_q, dec_flag_d;
  logic [CNT_W-1:0]  n_single_q, n_single_d;
  logic [CNT_W-1:0]  n_double_q, n_double_d;

  logic [10:0] syn_data;
  logic [1:0]  syn_flag;

  // In CHECK the MSW is on mem_rdata; the decode result is registered there,
  // so mem_rdata only ever reaches flops, never an output.
  ecc_syndrome u_syndrome (
    .code_i ({mem_rdata, lsw_q}),
    .data_o (syn_data),
    .flag_o (syn_flag)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      src_q      <= '0;
      dst_q      <= '0;
      rem_q      <= '0;
      lsw_q      <= '0;
      dec_data_q <= '0;
      dec_flag_q <= '0;
      n_single_q <= '0;
      n_double_q <= '0;
    end else begin
      state_q    <= state_d;
      src_q      <= src_d;
      dst_q      <= dst_d;
      rem_q      <= rem_d;
      lsw_q      <= lsw_d;
      dec_data_q <= dec_data_d;
      dec_flag_q <= dec_flag_d;
      n_single_q <= n_single_d;
      n_double_q <= n_double_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    src_d      = src_q;
    dst_d      = dst_q;
    rem_d      = rem_q;
    lsw_d      = lsw_q;
    dec_data_d = dec_data_q;
    dec_flag_d = dec_flag_q;
    n_single_d = n_single_q;
    n_double_d = n_double_q;
    mem_addr   = '0;
    mem_we     = 1'b0;
    mem_wdata  = '0;
    busy       = 1'b0;
    done       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          src_d      = src_base;
          dst_d      = dst_base;
          rem_d      = count;
          n_single_d = '0;
          n_double_d = '0;
          state_d    = (count == '0) ? ST_DONE : ST_RD_LO;
        end
      end
      ST_RD_LO: begin
        busy     = 1'b1;
        mem_addr = src_q;
        state_d  = ST_RD_HI;
      end
      ST_RD_HI: begin
        busy     = 1'b1;
        mem_addr = src_q + ADDR_W'(1);
        lsw_d    = mem_rdata;
        state_d  = ST_CHECK;
      end
      ST_CHECK: begin
        busy       = 1'b1;
        dec_data_d = syn_data;
        dec_flag_d = syn_flag;
        state_d    = ST_WR_LO;
      end
      ST_WR_LO: begin
        busy      = 1'b1;
        mem_addr  = dst_q;
        mem_we    = 1'b1;
        mem_wdata = dec_data_q[7:0];
        state_d   = ST_WR_HI;
      end
      ST_WR_HI: begin
        busy      = 1'b1;
        mem_addr  = dst_q + ADDR_W'(1);
        mem_we    = 1'b1;
        mem_wdata = {dec_flag_q, 3'b000, dec_data_q[10:8]};
        if (dec_flag_q == ECC_SEC && n_single_q != '1) begin
          n_single_d = n_single_q + CNT_W'(1);
        end
        if (dec_flag_q == ECC_DED && n_double_q != '1) begin
          n_double_d = n_double_q + CNT_W'(1);
        end
        src_d   = src_q + ADDR_W'(2);
        dst_d   = dst_q + ADDR_W'(2);
        rem_d   = rem_q - CNT_W'(1);
        state_d = (rem_q == CNT_W'(1)) ? ST_DONE : ST_RD_LO;
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign n_single = n_single_q;
  assign n_double = n_double_q;

endmodule
